// File: rtl/filter_pkg.sv
// Shared widths and state encoding for the filter sequencer.
package filter_pkg;
  localparam int SAMPLE_W = 8;
  localparam int RESULT_W = 32;
  localparam int GAP_W    = 16;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/filter_fifo.sv
// Synchronous sample FIFO; pointers carry one extra wrap bit to tell full from empty.
module filter_fifo
  import filter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [SAMPLE_W-1:0] wdata_i,
  input  logic                pop_i,
  output logic [SAMPLE_W-1:0] rdata_o,
  output logic                full_o,
  output logic                empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [AW:0]         wptr_q;
  logic [AW:0]         rptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/filter_seq.sv
// Feeds buffered samples into an external filter, flushes its delay line with zeros,
// and tags each sample so only results of real samples are strobed out.
module filter_seq
  import filter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LATENCY   = 2,
  parameter int FLUSH_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] flt_x,
  input  logic [RESULT_W-1:0] flt_y,
  output logic [RESULT_W-1:0] m_data,
  output logic                m_valid,
  output logic                busy,
  output logic [GAP_W-1:0]    gap_cnt
);
  localparam logic [7:0] FLUSH_INIT = 8'(FLUSH_LEN);

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [SAMPLE_W-1:0] flt_x_q;
  logic [LATENCY:0]    tag_q;
  logic [RESULT_W-1:0] m_data_q;
  logic                m_valid_q;
  logic [GAP_W-1:0]    gap_q;
  logic                rdy_en_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                push;
  logic                pop;

  // rdy_en_q keeps s_ready low until the first edge after reset release
  assign s_ready = rdy_en_q && !fifo_full;
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_RUN) && !fifo_empty;

  filter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (s_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FLUSH;
      cnt_q     <= FLUSH_INIT;
      flt_x_q   <= '0;
      tag_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      gap_q     <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      // tags keep shifting in both states so in-flight results still emerge
      tag_q     <= {tag_q[LATENCY-1:0], pop};
      m_valid_q <= tag_q[LATENCY];
      if (tag_q[LATENCY]) m_data_q <= flt_y;

      case (state_q)
        ST_FLUSH: begin
          flt_x_q <= '0;
          if (flush)               cnt_q   <= FLUSH_INIT;
          else if (cnt_q == 8'd1)  state_q <= ST_RUN;
          else                     cnt_q   <= cnt_q - 8'd1;
        end
        ST_RUN: begin
          flt_x_q <= pop ? fifo_head : '0;
          if (!pop && gap_q != '1) gap_q <= gap_q + 1'b1;
          if (flush) begin
            state_q <= ST_FLUSH;
            cnt_q   <= FLUSH_INIT;
          end
        end
        default: state_q <= ST_FLUSH;
      endcase
    end
  end

  assign flt_x   = flt_x_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign busy    = (state_q == ST_FLUSH);
  assign gap_cnt = gap_q;
endmodule

// File: tb/tb_filter_seq.sv
// Scoreboard bench for filter_seq with a behavioural LATENCY-deep filter model.
module tb_filter_seq;
  import filter_pkg::*;

  localparam int LAT = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [SAMPLE_W-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic                flush = 1'b0;
  logic [SAMPLE_W-1:0] flt_x;
  logic [RESULT_W-1:0] flt_y;
  logic [RESULT_W-1:0] m_data;
  logic                m_valid;
  logic                busy;
  logic [GAP_W-1:0]    gap_cnt;

  always #5 clk = ~clk;

  filter_seq #(.DEPTH(4), .LATENCY(LAT), .FLUSH_LEN(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .flush   (flush),
    .flt_x   (flt_x),
    .flt_y   (flt_y),
    .m_data  (m_data),
    .m_valid (m_valid),
    .busy    (busy),
    .gap_cnt (gap_cnt)
  );

  // filter model: y = 0x1000_0000 + 257*x, LAT register stages
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= 32'h1000_0000 + 32'(flt_x) * 32'd257;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign flt_y = pipe[LAT-1];

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] exp_q [$];
  int          busy_run = 0;
  int          last_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (reset && m_valid) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_m_valid: got m_data %h expected no strobe at %0t", m_data, $time);
      end else begin
        chk("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run > 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic push_one(input logic [7:0] d, input logic [31:0] e);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk_cnt++;
      $display("FAIL push_timeout: got s_ready 0 expected 1 for data %h", d);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_run();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk_cnt++;
      $display("FAIL run_timeout: got busy 1 expected 0");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d results outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy",    32'(busy),    32'd1);
    chk("rst_flt_x",   32'(flt_x),   32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  m_data,       32'd0);
    chk("rst_gap_cnt", 32'(gap_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // flush after release, then gap counting
    for (int i = 0; i < 8; i++) begin
      chk("flush_busy",  32'(busy),  32'd1);
      chk("flush_flt_x", 32'(flt_x), 32'd0);
      if (i > 0) chk("s_ready_after_release", 32'(s_ready), 32'd1);
      @(negedge clk);
    end
    chk("run_busy", 32'(busy), 32'd0);
    chk("gap_start", 32'(gap_cnt), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("gap_cnt", 32'(gap_cnt), 32'(i));
    end

    // back-to-back 1,2,3
    push_one(8'h01, 32'h1000_0101);
    push_one(8'h02, 32'h1000_0202);
    chk("flt_x_1", 32'(flt_x), 32'd1);
    push_one(8'h03, 32'h1000_0303);
    chk("flt_x_2", 32'(flt_x), 32'd2);
    s_valid = 1'b0;
    @(negedge clk);
    chk("flt_x_3", 32'(flt_x), 32'd3);
    wait_drain();

    // fill FIFO during flush
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_entered", 32'(busy), 32'd1);
    push_one(8'h0A, 32'h1000_0A0A);
    push_one(8'h14, 32'h1000_1414);
    push_one(8'h1E, 32'h1000_1E1E);
    push_one(8'h28, 32'h1000_2828);
    s_valid = 1'b1;
    s_data  = 8'h32;
    chk("full_s_ready", 32'(s_ready), 32'd0);
    chk("full_busy",    32'(busy),    32'd1);
    push_one(8'h32, 32'h1000_3232);
    s_valid = 1'b0;
    wait_drain();

    // flush with two samples in flight and two queued
    push_one(8'h3C, 32'h1000_3C3C);
    push_one(8'h3D, 32'h1000_3D3D);
    flush = 1'b1;
    push_one(8'h3E, 32'h1000_3E3E);
    flush = 1'b0;
    push_one(8'h3F, 32'h1000_3F3F);
    s_valid = 1'b0;
    wait_run();
    #1;
    chk("flush_busy_len", 32'(last_run), 32'd8);
    wait_drain();

    // reset mid-stream with a full FIFO and samples in flight
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_one(8'h5A, 32'h1000_5A5A);
    push_one(8'h5B, 32'h1000_5B5B);
    push_one(8'h5C, 32'h1000_5C5C);
    push_one(8'h5D, 32'h1000_5D5D);
    s_valid = 1'b1;
    s_data  = 8'h5E;
    chk("full2_s_ready", 32'(s_ready), 32'd0);
    push_one(8'h5E, 32'h1000_5E5E);
    s_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_flt_x",   32'(flt_x),   32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_data",  m_data,       32'd0);
    chk("mid_rst_gap",     32'(gap_cnt), 32'd0);
    chk("mid_rst_busy",    32'(busy),    32'd1);
    chk("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_run();
    @(negedge clk);
    chk("gap_after_reset", 32'(gap_cnt), 32'd1);
    chk("flt_x_after_reset", 32'(flt_x), 32'd0);
    push_one(8'h07, 32'h1000_0707);
    s_valid = 1'b0;
    wait_drain();

    // gap counter saturation
    @(negedge clk);
    force dut.gap_q = 16'hFFFE;
    @(negedge clk);
    release dut.gap_q;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_saturate", 32'(gap_cnt), 32'h0000_FFFF);
    end

    repeat (6) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion before 100us");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/filter_seq.md
FILTER_SEQ -- requirements
Module: filter_seq

Interface
REQ-001 Parameter DEPTH, default 4: input FIFO depth in samples, power of two, 2..16.
REQ-002 Parameter LATENCY, default 2: clock edges from a sample on flt_x to its result on flt_y, range 1..8.
REQ-003 Parameter FLUSH_LEN, default 8: zero samples driven into the filter per flush, range 1..255.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-006 s_data  in  8  sample from the upstream source.
REQ-007 s_valid  in  1  s_data valid.
REQ-008 s_ready  out  1  block accepts s_data this cycle.
REQ-009 flush  in  1  one-cycle request to clear the filter delay line.
REQ-010 flt_x  out  8  registered sample to the filter's x input.
REQ-011 flt_y  in  32  filter's out.
REQ-012 m_data  out  32  captured filter result.
REQ-013 m_valid  out  1  one-cycle strobe; m_data holds a result belonging to a real sample.
REQ-014 busy  out  1  high while in FLUSH.
REQ-015 gap_cnt  out  16  count of RUN cycles with an empty FIFO.

Function
REQ-016 Transfer on s_valid&&s_ready at posedge; s_ready = FIFO not full, in every state; no combinational path from s_valid to s_ready.
REQ-017 States FLUSH and RUN only; FLUSH is entered on reset release and on flush.
REQ-018 FLUSH: flt_x=0 for FLUSH_LEN consecutive cycles, no FIFO pop, busy=1; the push side stays active; the cycle after the last zero enters RUN.
REQ-019 flush seen in RUN -> FLUSH next edge, counter loaded with FLUSH_LEN; flush seen in FLUSH restarts the count; FIFO contents are kept in both cases.
REQ-020 RUN, FIFO non-empty: pop head, flt_x <= head, tag=1; FIFO empty: flt_x <= 0, tag=0, gap_cnt increments, saturating at 16'hFFFF.
REQ-021 A sample pushed into an empty FIFO is poppable at the earliest on the next edge; simultaneous push and pop when not full is legal, and occupancy is unchanged.
REQ-022 The tag is carried through a LATENCY+1 stage shift register; zeros from FLUSH carry tag=0.
REQ-023 Sample presented on flt_x after edge k -> m_data<=flt_y and m_valid=1 after edge k+LATENCY+1; m_data holds between strobes.
REQ-024 In-flight tags keep shifting during FLUSH; results of real samples already sent still emerge.
REQ-025 There is no downstream backpressure; m_valid is never stalled.
REQ-026 Sample order at m_data equals acceptance order at s_data.

Reset
REQ-027 reset low -> immediately: FIFO empty, tags 0, flt_x=0, m_data=0, m_valid=0, gap_cnt=0, state FLUSH with counter=FLUSH_LEN, busy=1, s_ready=0.
REQ-028 s_ready=0 while reset is low, and = FIFO not full from the first edge after release.
REQ-029 Reset asserted mid-operation discards all buffered and in-flight samples; no m_valid from them.

Structure
REQ-030 Package filter_pkg holds the state encoding, the sample width (8), the result width (32) and the gap_cnt width (16).
REQ-031 One sub-module, filter_fifo: synchronous DEPTH x 8 FIFO with full/empty, async active-low reset, same clk/reset names.
REQ-032 filter_seq instantiates filter_fifo only; the filter is connected at the next level up.

Verification
REQ-033 Reset release, s_valid=0 -> busy=1 for exactly 8 cycles, flt_x=0 throughout, then RUN and gap_cnt counts 1,2,3...
REQ-034 Push 1,2,3 back-to-back after FLUSH, LATENCY=2 -> flt_x shows 1,2,3 on consecutive cycles; three m_valid strobes 3 edges later carry flt_y for those cycles.
REQ-035 s_valid held high, no pops (inside FLUSH) -> exactly 4 samples accepted, s_ready=0 on the 5th, the FIFO drains in order after FLUSH.
REQ-036 flush pulse with 2 samples in flight -> both results still strobe, busy=1 for 8 cycles, queued samples resume after them.
REQ-037 reset low for 1 cycle mid-stream with a full FIFO -> all outputs 0 immediately, no stale m_valid, FLUSH restarts.
REQ-038 Force gap_cnt to 16'hFFFE, run 3 empty RUN cycles -> holds at 16'hFFFF.
